// File: rtl/panel_scan_if.sv
`default_nettype none
// ============================================================================
// panel_scan_if
// ----------------------------------------------------------------------------
// Framebuffer display-side read bus.
//   row   : read row (driven by the scanner)
//   col   : read col, col[5] selects lower half, col[4:0] is pixel x
//   red/green/blue : read data, valid the cycle after row/col are presented
// Modports:
//   master : the scanner (drives the address, receives pixel data)
//   slave  : the framebuffer (receives the address, returns pixel data)
// Revision: 1.0 - initial release
// ============================================================================
interface panel_scan_if;
  logic [2:0] row;
  logic [5:0] col;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;

  modport master (output row, col, input  red, green, blue);
  modport slave  (input  row, col, output red, green, blue);
endinterface
`default_nettype wire

// File: rtl/panel_scan.sv
`default_nettype none
// ============================================================================
// panel_scan
// ----------------------------------------------------------------------------
// Display-side reader of the double-buffered LED framebuffer. Walks the
// framebuffer row by row, fetches upper/lower half pixels and drives a
// HUB75-style 1/8-scan panel with binary-coded modulation (BCM). Each row is
// shown DEPTH times (one bit plane per pass, LSB first); plane b keeps the
// LEDs on for LSB_HOLD<<b cycles. frame_done pulses once per full frame so
// the update side can swap buffers.
//
// Ports:
//   clk        : system clock, also the framebuffer display clock
//   rst_n      : asynchronous active-low reset
//   enable     : scanning allowed (sampled only when a plane finishes)
//   fb         : framebuffer read bus (master side)
//   r0,g0,b0   : upper-half panel data
//   r1,g1,b1   : lower-half panel data
//   pclk       : panel shift clock (panel samples on rising edge)
//   lat        : panel latch strobe
//   oe_n       : panel output enable, active low
//   a          : panel row select
//   frame_done : one-cycle pulse after the last plane of row 7
//
// Parameters:
//   COLS     : pixels shifted per half-row per plane (1..32)
//   DEPTH    : number of BCM bit planes (1..8)
//   LSB_HOLD : display cycles of plane 0
// Revision: 1.0 - initial release
// ============================================================================
module panel_scan #(
  parameter int COLS     = 32,
  parameter int DEPTH    = 8,
  parameter int LSB_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  panel_scan_if.master fb,
  output logic         r0,
  output logic         g0,
  output logic         b0,
  output logic         r1,
  output logic         g1,
  output logic         b1,
  output logic         pclk,
  output logic         lat,
  output logic         oe_n,
  output logic [2:0]   a,
  output logic         frame_done
);

  localparam int XW       = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_HOLD = LSB_HOLD << (DEPTH - 1);
  // Sized for the longest plane so the down-counter never overflows.
  localparam int HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_TAIL  = 3'd2,
    S_LATCH = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t          state_q;
  logic [1:0]      ph_q;       // pixel phase within SHIFT
  logic [XW-1:0]   x_q;        // pixel x within the half-row
  logic [PW-1:0]   plane_q;    // current BCM bit plane
  logic [2:0]      row_q;      // current scan row
  logic [5:0]      col_q;      // framebuffer read column
  logic            tail_q;     // second TAIL cycle marker
  logic [HW-1:0]   hold_q;     // remaining SHOW cycles minus one
  logic [2:0]      stage_q;    // upper-half bits waiting for the lower half
  logic            r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
  logic            pclk_q, lat_q, oe_n_q, fd_q;
  logic [2:0]      a_q;

  logic [2:0]      bsel_d;     // bit of the colour word used by this plane
  logic [HW-1:0]   hold_init_d;
  logic [XW-1:0]   x_inc_d;
  logic [PW-1:0]   plane_inc_d;

  always_comb begin
    bsel_d      = 3'(plane_q);
    hold_init_d = HW'((LSB_HOLD << plane_q) - 1);
    x_inc_d     = XW'(x_q + 1'b1);
    plane_inc_d = PW'(plane_q + 1'b1);
  end

  // --------------------------------------------------------------------------
  // Scan FSM. Every output is a register updated here.
  //
  // Pixel x takes four SHIFT cycles:
  //   p0 : col={0,x} on the bus
  //   p1 : col={1,x}; upper pixel data is on the bus -> stage it
  //   p2 : lower pixel data on the bus -> load both halves onto r0..b1
  //   p3 : hold
  // pclk is high during p0/p1 of pixel x+1, so the rising edge comes one
  // cycle after the data change and the falling edge one cycle before the
  // next change. The last pixel is clocked in by the two TAIL cycles.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= 2'd0;
      x_q     <= '0;
      plane_q <= '0;
      row_q   <= 3'd0;
      col_q   <= 6'd0;
      tail_q  <= 1'b0;
      hold_q  <= '0;
      stage_q <= 3'd0;
      r0_q    <= 1'b0;
      g0_q    <= 1'b0;
      b0_q    <= 1'b0;
      r1_q    <= 1'b0;
      g1_q    <= 1'b0;
      b1_q    <= 1'b0;
      pclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      fd_q    <= 1'b0;
      a_q     <= 3'd0;
    end else begin
      fd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          oe_n_q <= 1'b1;
          pclk_q <= 1'b0;
          lat_q  <= 1'b0;
          if (enable) begin
            state_q <= S_SHIFT;
            row_q   <= 3'd0;
            plane_q <= '0;
            x_q     <= '0;
            ph_q    <= 2'd0;
            col_q   <= 6'd0;
          end
        end

        S_SHIFT: begin
          case (ph_q)
            2'd0: begin
              // pclk keeps the level set on entry to p0
              ph_q  <= 2'd1;
              col_q <= {1'b1, 5'(x_q)};
            end
            2'd1: begin
              ph_q    <= 2'd2;
              pclk_q  <= 1'b0;
              stage_q <= {fb.red[bsel_d], fb.green[bsel_d], fb.blue[bsel_d]};
            end
            2'd2: begin
              ph_q <= 2'd3;
              {r0_q, g0_q, b0_q} <= stage_q;
              r1_q <= fb.red[bsel_d];
              g1_q <= fb.green[bsel_d];
              b1_q <= fb.blue[bsel_d];
            end
            default: begin
              pclk_q <= 1'b1;
              if (x_q == X_LAST) begin
                state_q <= S_TAIL;
                tail_q  <= 1'b0;
              end else begin
                x_q   <= x_inc_d;
                ph_q  <= 2'd0;
                col_q <= {1'b0, 5'(x_inc_d)};
              end
            end
          endcase
        end

        S_TAIL: begin
          if (!tail_q) begin
            tail_q <= 1'b1;
          end else begin
            state_q <= S_LATCH;
            pclk_q  <= 1'b0;
            lat_q   <= 1'b1;
            // Row select moves only while the LEDs are blanked.
            a_q     <= row_q;
          end
        end

        S_LATCH: begin
          state_q <= S_SHOW;
          lat_q   <= 1'b0;
          oe_n_q  <= 1'b0;
          hold_q  <= hold_init_d;
        end

        S_SHOW: begin
          if (hold_q == '0) begin
            oe_n_q <= 1'b1;
            x_q    <= '0;
            ph_q   <= 2'd0;
            col_q  <= 6'd0;
            if (row_q == 3'd7 && plane_q == P_LAST) begin
              fd_q <= 1'b1;
            end
            if (!enable) begin
              state_q <= S_IDLE;
              row_q   <= 3'd0;
              plane_q <= '0;
            end else begin
              state_q <= S_SHIFT;
              if (plane_q != P_LAST) begin
                plane_q <= plane_inc_d;
              end else begin
                plane_q <= '0;
                row_q   <= row_q + 3'd1;
              end
            end
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          oe_n_q  <= 1'b1;
          pclk_q  <= 1'b0;
          lat_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fb.row     = row_q;
  assign fb.col     = col_q;
  assign r0         = r0_q;
  assign g0         = g0_q;
  assign b0         = b0_q;
  assign r1         = r1_q;
  assign g1         = g1_q;
  assign b1         = b1_q;
  assign pclk       = pclk_q;
  assign lat        = lat_q;
  assign oe_n       = oe_n_q;
  assign a          = a_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_panel_scan.sv
`default_nettype none
// ============================================================================
// tb_panel_scan
// ----------------------------------------------------------------------------
// Bench for panel_scan. A default-parameter instance reads a framebuffer
// model filled with random, all-A5 and {x,half} contents; a second instance
// (COLS=4, DEPTH=1, LSB_HOLD=1) runs alongside for frame timing. An event
// model of the panel protocol predicts shifted bits, pclk counts, SHOW
// widths, row select and frame_done.
// Revision: 1.0 - initial release
// ============================================================================
module tb_panel_scan;

  localparam int COLS     = 32;
  localparam int DEPTH    = 8;
  localparam int LSB_HOLD = 4;
  localparam int FRAME    = 8 * (DEPTH * (4 * COLS + 3) + LSB_HOLD * ((1 << DEPTH) - 1));
  localparam int S_COLS   = 4;
  localparam int S_FRAME  = 8 * (4 * S_COLS + 2 + 1 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en0, en1;

  panel_scan_if fb0 ();
  panel_scan_if fb1 ();

  logic r0, g0, b0, r1, g1, b1, pclk, lat, oe_n, fd;
  logic [2:0] a;
  logic s_r0, s_g0, s_b0, s_r1, s_g1, s_b1, s_pclk, s_lat, s_oe, s_fd;
  logic [2:0] s_a;

  panel_scan dut (
    .clk(clk), .rst_n(rst_n), .enable(en0), .fb(fb0),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .pclk(pclk), .lat(lat), .oe_n(oe_n), .a(a), .frame_done(fd)
  );

  panel_scan #(.COLS(S_COLS), .DEPTH(1), .LSB_HOLD(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fb(fb1),
    .r0(s_r0), .g0(s_g0), .b0(s_b0), .r1(s_r1), .g1(s_g1), .b1(s_b1),
    .pclk(s_pclk), .lat(s_lat), .oe_n(s_oe), .a(s_a), .frame_done(s_fd)
  );

  logic [5:0] dat, s_dat;
  assign dat   = {r0, g0, b0, r1, g1, b1};
  assign s_dat = {s_r0, s_g0, s_b0, s_r1, s_g1, s_b1};

  // Framebuffer contents [half][row][x]
  logic [7:0] mr [2][8][32];
  logic [7:0] mg [2][8][32];
  logic [7:0] mb [2][8][32];

  // Synchronous-read framebuffer models: data valid the cycle after address.
  always @(posedge clk) begin
    fb0.red   <= mr[fb0.col[5]][fb0.row][fb0.col[4:0]];
    fb0.green <= mg[fb0.col[5]][fb0.row][fb0.col[4:0]];
    fb0.blue  <= mb[fb0.col[5]][fb0.row][fb0.col[4:0]];
    fb1.red   <= {2'b00, fb1.col};
    fb1.green <= ~{2'b00, fb1.col};
    fb1.blue  <= 8'h00;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_bits(input int row, input int x, input int b);
    logic [7:0] ur, ug, ub, lr, lg, lb;
    ur = mr[0][row][x]; ug = mg[0][row][x]; ub = mb[0][row][x];
    lr = mr[1][row][x]; lg = mg[1][row][x]; lb = mb[1][row][x];
    return {ur[b], ug[b], ub[b], lr[b], lg[b], lb[b]};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic en_q;
  always @(posedge clk) en_q <= en0;

  // ---------------- reference model, default instance ----------------
  int   shift_cnt, show_len, exp_row, exp_plane, last_fd;
  bit   fd_valid, oe_rise, wrap;
  logic p_pclk, p_oe, p_lat;
  logic [2:0] p_a;
  logic [5:0] p_dat;

  always @(negedge clk) begin
    if (!rst_n) begin
      shift_cnt = 0; show_len = 0; exp_row = 0; exp_plane = 0; fd_valid = 0;
    end else begin
      if (pclk && !p_pclk) begin
        chk("setup", dat, p_dat);
        if (shift_cnt < COLS) chk("pix", dat, exp_bits(exp_row, shift_cnt, exp_plane));
        shift_cnt++;
      end
      if (!pclk && p_pclk) chk("hold", dat, p_dat);
      if (pclk || lat) chk("oe_blank", oe_n, 1);
      if (a != p_a) chk("a_chg", {lat, oe_n}, 2'b11);
      if (lat && !p_lat) begin
        chk("pclk_cnt", shift_cnt, COLS);
        chk("a_row", a, exp_row);
        chk("row_addr", fb0.row, exp_row);
        shift_cnt = 0;
      end
      if (!oe_n) show_len++;
      oe_rise = oe_n && !p_oe;
      wrap    = (exp_row == 7) && (exp_plane == DEPTH - 1);
      if (fd || oe_rise) chk("fdone", fd, oe_rise && wrap);
      if (oe_rise) begin
        chk("show_w", show_len, LSB_HOLD << exp_plane);
        show_len = 0;
        if (!en_q) begin
          exp_row = 0; exp_plane = 0; fd_valid = 0;
        end else if (exp_plane < DEPTH - 1) begin
          exp_plane++;
        end else begin
          exp_plane = 0;
          exp_row   = (exp_row + 1) % 8;
        end
      end
      if (fd) begin
        if (fd_valid) chk("frame_len", cyc - last_fd, FRAME);
        last_fd  = cyc;
        fd_valid = 1;
      end
    end
    p_pclk = pclk; p_oe = oe_n; p_lat = lat; p_a = a; p_dat = dat;
  end

  // ---------------- reference model, small instance ----------------
  int   s_cnt, s_show, s_last;
  bit   s_valid;
  logic q_pclk, q_oe, q_lat;
  logic [5:0] s_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_cnt = 0; s_show = 0; s_valid = 0;
    end else begin
      if (s_pclk && !q_pclk) begin
        // red = {0,col}, green = ~{0,col}: plane 0 carries x[0] on both halves
        s_exp = {s_cnt[0], ~s_cnt[0], 1'b0, s_cnt[0], ~s_cnt[0], 1'b0};
        chk("s_pix", s_dat, s_exp);
        s_cnt++;
      end
      if (s_lat && !q_lat) begin
        chk("s_pclk_cnt", s_cnt, S_COLS);
        s_cnt = 0;
      end
      if (!s_oe) s_show++;
      if (s_oe && !q_oe) begin
        chk("s_show_w", s_show, 1);
        s_show = 0;
      end
      if (s_fd) begin
        if (s_valid) chk("s_frame_len", cyc - s_last, S_FRAME);
        s_last  = cyc;
        s_valid = 1;
      end
    end
    q_pclk = s_pclk; q_oe = s_oe; q_lat = s_lat;
  end

  // ---------------- stimulus ----------------
  int  nfd;
  bit  hit;

  initial begin
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 8; r++)
        for (int x = 0; x < 32; x++) begin
          mr[h][r][x] = 8'($urandom);
          mg[h][r][x] = 8'($urandom);
          mb[h][r][x] = 8'($urandom);
        end
    repeat (3) @(negedge clk);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_pclk", pclk, 0);
    chk("rst_lat",  lat, 0);
    chk("rst_a",    a, 0);
    chk("rst_fd",   fd, 0);
    chk("rst_dat",  dat, 0);
    chk("rst_col",  fb0.col, 0);
    chk("rst_s_oe", s_oe, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    en0 = 1'b1; en1 = 1'b1;

    // Random contents, two full frames
    nfd = 0;
    for (int i = 0; i < 2 * FRAME + 4000 && nfd < 2; i++) begin
      @(negedge clk);
      if (fd) nfd++;
    end
    chk("to_frames", nfd, 2);

    // Drop enable while shifting row 3, plane 2
    hit = 0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      @(negedge clk);
      hit = (exp_row == 3) && (exp_plane == 2) && pclk;
    end
    chk("to_r3p2", hit, 1);
    en0 = 1'b0;
    for (int i = 0; i < 400 && oe_n; i++) @(negedge clk);
    chk("to_show", oe_n, 0);
    for (int i = 0; i < 400 && !oe_n; i++) @(negedge clk);
    chk("to_idle", oe_n, 1);
    repeat (40) begin
      @(negedge clk);
      chk("idle_quiet", {oe_n, pclk, lat, fd}, 4'b1000);
    end

    // All pixels 8'hA5, one full frame from row 0 plane 0
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 8; r++)
        for (int x = 0; x < 32; x++) begin
          mr[h][r][x] = 8'hA5; mg[h][r][x] = 8'hA5; mb[h][r][x] = 8'hA5;
        end
    en0 = 1'b1;
    nfd = 0;
    for (int i = 0; i < FRAME + 2000 && nfd < 1; i++) begin
      @(negedge clk);
      if (fd) nfd++;
    end
    chk("to_a5_frame", nfd, 1);

    // Asynchronous reset while LEDs are on
    for (int i = 0; i < 500 && oe_n; i++) @(negedge clk);
    chk("to_show2", oe_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe_n", oe_n, 1);
    chk("arst_lat",  lat, 0);
    chk("arst_pclk", pclk, 0);
    chk("arst_fd",   fd, 0);
    chk("arst_a",    a, 0);
    chk("arst_s_oe", s_oe, 1);

    // {x,half} pattern, restart after reset
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 8; r++)
        for (int x = 0; x < 32; x++) begin
          mr[h][r][x] = 8'((x << 1) | h);
          mg[h][r][x] = ~8'((x << 1) | h);
          mb[h][r][x] = 8'((x << 1) | h) ^ 8'(r << 6);
        end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    hit = 0;
    for (int i = 0; i < 3 * 2068 && !hit; i++) begin
      @(negedge clk);
      hit = (exp_row == 2);
    end
    chk("to_pattern", hit, 1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
